// File: rtl/bcd_pkg.sv
// Shared definitions for the ASCII-to-BCD collector: FSM states, ASCII codes
// and the BCD digit width.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BS   = 8'h08;

  typedef enum logic [1:0] {
    EMPTY,
    COLLECT,
    ISSUE,
    WAIT
  } state_e;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational byte classifier: decimal digit, terminator, backspace.
// Backspace is recognised only when ASCII_BCD_BACKSPACE_EN is defined.
module ascii_digit_decode
  import bcd_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input  logic [7:0]       rx_data_i,
  output logic             is_digit_o,
  output logic             is_term_o,
  output logic             is_bs_o,
  output logic [BCD_W-1:0] value_o
);

  always_comb begin
    is_digit_o = (rx_data_i >= ASCII_ZERO) && (rx_data_i <= ASCII_NINE);
    is_term_o  = (rx_data_i == TERM_CHAR);
`ifdef ASCII_BCD_BACKSPACE_EN
    is_bs_o    = (rx_data_i == ASCII_BS);
`else
    is_bs_o    = 1'b0;
`endif
    value_o    = rx_data_i[BCD_W-1:0];
  end

endmodule

// File: rtl/ascii_bcd_collector.sv
// Collects up to two ASCII decimal digits and hands them to the BCD-to-binary
// converter on a terminator. Optional backspace editing: ASCII_BCD_BACKSPACE_EN.
module ascii_bcd_collector
  import bcd_pkg::*;
#(
  parameter logic [7:0]  TERM_CHAR  = ASCII_CR,
  parameter int unsigned MAX_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             conv_ready,
  input  logic             conv_done,
  output logic             start,
  output logic [BCD_W-1:0] dig1,
  output logic [BCD_W-1:0] dig0,
  output logic             busy,
  output logic             err_tick,
  output logic             overrun_tick
);

  if (MAX_DIGITS != 2) begin : g_bad_max_digits
    $error("ascii_bcd_collector: MAX_DIGITS must be 2 to match the converter");
  end

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [BCD_W-1:0] dig1_q, dig1_d, dig0_q, dig0_d;
  logic             err_q, err_d, ovr_q, ovr_d;

  logic             is_digit, is_term, is_bs;
  logic [BCD_W-1:0] value;

  ascii_digit_decode #(
    .TERM_CHAR (TERM_CHAR)
  ) u_decode (
    .rx_data_i  (rx_data),
    .is_digit_o (is_digit),
    .is_term_o  (is_term),
    .is_bs_o    (is_bs),
    .value_o    (value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      dig1_q  <= '0;
      dig0_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    start   = 1'b0;
    case (state_q)
      EMPTY, COLLECT: begin
        if (rx_valid) begin
          if (is_digit) begin
            if (count_q == 2'd0) begin
              dig1_d  = '0;
              dig0_d  = value;
              count_d = 2'd1;
              state_d = COLLECT;
            end else if (count_q == 2'd1) begin
              dig1_d  = dig0_q;
              dig0_d  = value;
              count_d = 2'd2;
            end else begin
              // overflow: the offending digit is discarded with the buffer
              err_d   = 1'b1;
              dig1_d  = '0;
              dig0_d  = '0;
              count_d = '0;
              state_d = EMPTY;
            end
          end else if (is_term) begin
            if (state_q == COLLECT) state_d = ISSUE;
          end else if (is_bs) begin
            if (count_q == 2'd2) begin
              dig0_d  = dig1_q;
              dig1_d  = '0;
              count_d = 2'd1;
            end else if (count_q == 2'd1) begin
              dig0_d  = '0;
              count_d = '0;
              state_d = EMPTY;
            end
          end else begin
            err_d   = 1'b1;
            dig1_d  = '0;
            dig0_d  = '0;
            count_d = '0;
            state_d = EMPTY;
          end
        end
      end
      ISSUE: begin
        ovr_d = rx_valid;
        if (conv_ready) begin
          start   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        ovr_d = rx_valid;
        if (conv_done) begin
          dig1_d  = '0;
          dig0_d  = '0;
          count_d = '0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign dig1         = dig1_q;
  assign dig0         = dig0_q;
  assign busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign err_tick     = err_q;
  assign overrun_tick = ovr_q;

endmodule

// File: tb/tb_ascii_bcd_collector.sv
// Scoreboard bench for ascii_bcd_collector: a digit-buffer reference model
// queues expected start/err/overrun events; a negedge monitor pops and compares.
module tb_ascii_bcd_collector;

`ifdef ASCII_BCD_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, conv_ready, conv_done;
  logic       start, busy, err_tick, overrun_tick;
  logic [3:0] dig1, dig0;

  ascii_bcd_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .conv_ready   (conv_ready),
    .conv_done    (conv_done),
    .start        (start),
    .dig1         (dig1),
    .dig0         (dig0),
    .busy         (busy),
    .err_tick     (err_tick),
    .overrun_tick (overrun_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;
  int starts_seen = 0, dones_issued = 0, last_start_cyc = -1;
  int buf_q[$];
  bit model_busy = 1'b0;
  int exp_start_q[$], exp_err_q[$], exp_ovr_q[$];
  bit prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_tens();
    return (buf_q.size() == 2) ? buf_q[0] : 0;
  endfunction

  function automatic int exp_units();
    return (buf_q.size() > 0) ? buf_q[buf_q.size()-1] : 0;
  endfunction

  function automatic bit in_flight();
    return starts_seen > dones_issued;
  endfunction

  function automatic logic [7:0] ch(input int n);
    return 8'(8'h30 + n);
  endfunction

  // Reference model: the collector is a buffer of at most two digit values
  task automatic model_byte(input logic [7:0] d);
    if (model_busy) begin
      exp_ovr_q.push_back(cyc + 1);
    end else if (d >= 8'h30 && d <= 8'h39) begin
      if (buf_q.size() == 2) begin
        exp_err_q.push_back(cyc + 1);
        buf_q.delete();
      end else begin
        buf_q.push_back(int'(d) - 48);
      end
    end else if (d == 8'h0D) begin
      if (buf_q.size() > 0) begin
        exp_start_q.push_back(exp_tens() * 16 + exp_units());
        model_busy = 1'b1;
      end
    end else if (BS_EN && d == 8'h08) begin
      if (buf_q.size() > 0) void'(buf_q.pop_back());
    end else begin
      exp_err_q.push_back(cyc + 1);
      buf_q.delete();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit done);
    bit eff_done;
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("busy", busy, model_busy);
      check("dig1", dig1, exp_tens());
      check("dig0", dig0, exp_units());
    end
    rx_valid   = v;
    rx_data    = d;
    conv_ready = rdy;
    conv_done  = done;
    eff_done   = done && in_flight();
    if (eff_done) dones_issued++;
    if (rst_n) begin
      if (v) model_byte(d);
      if (eff_done) begin
        model_busy = 1'b0;
        buf_q.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b1, in_flight());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b1, in_flight());
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start) begin
          starts_seen++;
          last_start_cyc = cyc;
          check("start_needs_ready", conv_ready, 1);
          if (prev_start) begin
            checks++; fails++;
            $display("FAIL start_width: got high 2 cycles, required 1 (cycle %0d)", cyc);
          end
          if (exp_start_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL start_spurious: got start dig1=%0d dig0=%0d, required none (cycle %0d)", dig1, dig0, cyc);
          end else begin
            int e;
            e = exp_start_q.pop_front();
            check("start_dig1", dig1, e / 16);
            check("start_dig0", dig0, e % 16);
          end
        end
        if (err_tick) begin
          if (exp_err_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL err_tick: got pulse, required none (cycle %0d)", cyc);
          end else check("err_tick_cycle", cyc, exp_err_q.pop_front());
        end else if (exp_err_q.size() > 0 && exp_err_q[0] <= cyc) begin
          checks++; fails++;
          $display("FAIL err_tick: got 0, required pulse at cycle %0d", exp_err_q.pop_front());
        end
        if (overrun_tick) begin
          if (exp_ovr_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL overrun_tick: got pulse, required none (cycle %0d)", cyc);
          end else check("overrun_tick_cycle", cyc, exp_ovr_q.pop_front());
        end else if (exp_ovr_q.size() > 0 && exp_ovr_q[0] <= cyc) begin
          checks++; fails++;
          $display("FAIL overrun_tick: got 0, required pulse at cycle %0d", exp_ovr_q.pop_front());
        end
      end
      prev_start = start;
    end
  end

  initial begin : stimulus
    int t, s0;
    logic [7:0] b;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; conv_ready = 1'b0; conv_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_dig1", dig1, 0);
    check("rst_dig0", dig0, 0);
    check("rst_err", err_tick, 0);
    check("rst_ovr", overrun_tick, 0);
    #3 rst_n = 1'b1;

    // "42" CR: start one cycle after the terminator is sampled
    send(ch(4)); send(ch(2));
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    t = cyc + 1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    check("start_latency", last_start_cyc, t);

    // "7" CR, then CR alone in EMPTY
    send(ch(7)); send(8'h0D); idle(4);
    s0 = starts_seen;
    send(8'h0D); idle(3);
    check("cr_in_empty_no_start", starts_seen, s0);

    // overflow on third digit, then "5" CR
    send(ch(1)); send(ch(2)); send(ch(3)); send(ch(5)); send(8'h0D); idle(4);

    // invalid character, then start held off by conv_ready
    send(ch(9)); send(8'h41);
    step(1'b1, ch(3), 1'b0, 1'b0);
    step(1'b1, 8'h0D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    t = cyc;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    check("start_on_ready_rise", last_start_cyc, t);

    // byte arriving together with conv_done in WAIT
    send(ch(1)); send(8'h0D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, ch(8), 1'b1, 1'b1);
    idle(3);

    // backspace (or error without the feature)
    send(ch(5)); send(ch(6)); send(8'h08); send(ch(1)); send(8'h0D); idle(4);

    // reset mid-operation after one digit
    send(ch(4));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_dig0", dig0, 0);
    check("midrst_dig1", dig1, 0);
    check("midrst_busy", busy, 0);
    check("midrst_start", start, 0);
    buf_q.delete();
    model_busy = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    s0 = starts_seen;
    send(8'h0D); idle(4);
    check("no_start_after_reset", starts_seen, s0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(19, 0));
      if (r < 10) b = ch(int'($urandom_range(9, 0)));
      else if (r < 13) b = 8'h0D;
      else if (r < 15) b = 8'h08;
      else b = 8'($urandom);
      step(1'($urandom), b, ($urandom % 4) != 0,
           in_flight() ? (($urandom % 3) == 0) : (($urandom % 16) == 0));
    end
    idle(30);

    check("start_queue_drained", exp_start_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);
    check("ovr_queue_drained", exp_ovr_q.size(), 0);
    check("conversions_closed", starts_seen, dones_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ascii_bcd_collector.md
Name: ascii_bcd_collector

Overview:
- Upstream feeder for the 2-digit BCD-to-binary converter.
- Consumes ASCII characters from the UART receiver (one-cycle rx_valid strobe per byte) and accumulates up to two decimal digits.
- On a terminator character, presents them as dig1/dig0 and issues a one-cycle start to the converter.
- Holds the digits stable until the converter's done_tick returns, then accepts the next number.

Parameters:
- TERM_CHAR, 8'h0D, ASCII code that ends a number (CR).
- MAX_DIGITS, 2, digit capacity; fixed at 2 to match the converter's dig1/dig0 inputs; any other value is a synthesis error.

Ports:
- clk  in  1  clock; reset rst_n, asynchronous, active-low.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received ASCII byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- conv_ready  in  1  converter idle and able to accept start.
- conv_done  in  1  converter done_tick (one cycle).
- start  out  1  one-cycle start pulse to the converter.
- dig1  out  4  tens digit (BCD 0..9).
- dig0  out  4  units digit (BCD 0..9).
- busy  out  1  high from terminator acceptance until conv_done.
- err_tick  out  1  one-cycle pulse: invalid character or digit overflow.
- overrun_tick  out  1  one-cycle pulse: byte dropped while busy.

Behaviour:
- Reset values: state EMPTY, count=0, dig1=0, dig0=0. start, busy, err_tick and overrun_tick are all 0.
- States:
  - EMPTY (count 0).
  - COLLECT (count 1 or 2).
  - ISSUE (waiting to launch).
  - WAIT (conversion in flight).
- Bytes are examined only when rx_valid=1. Classification:
  - digit: 0x30..0x39, value = rx_data[3:0].
  - terminator: TERM_CHAR.
  - other: anything else.
- Digit in EMPTY: dig1←0, dig0←value, count←1, go to COLLECT.
- Digit in COLLECT with count=1: dig1←dig0, dig0←value, count←2.
- Digit with count=2: overflow.
  - err_tick=1 for one cycle.
  - dig1, dig0 and count cleared; go to EMPTY.
  - The offending digit is discarded.
- Terminator in EMPTY: ignored, no error, no start.
- Terminator in COLLECT: go to ISSUE, busy←1. With count=1, dig1 is already 0, so "7\r" yields dig1=0, dig0=7.
- Other character in EMPTY/COLLECT: err_tick pulse, buffer cleared, go to EMPTY.
- ISSUE: start = (state==ISSUE) & conv_ready, asserted combinationally for exactly one cycle. On that same edge, go to WAIT. ISSUE persists indefinitely while conv_ready=0.
- WAIT: on conv_done go to EMPTY. On that edge, busy←0, count←0, and dig1/dig0 are cleared.
- dig1/dig0 are registered and stable throughout ISSUE and WAIT.
- Any rx_valid in ISSUE/WAIT gives an overrun_tick pulse; the byte is dropped. This also applies when it coincides with conv_done in WAIT: the byte is dropped and the transition to EMPTY still occurs.
- Latency: terminator sampled at edge N → ISSUE from N. start is high in cycle N+1 if conv_ready=1.
- conv_done outside WAIT is ignored.
- Reset mid-operation: all state and outputs return to reset values asynchronously. Partial digits are lost and no start is issued.

Optional Feature:
- Macro ASCII_BCD_BACKSPACE_EN.
- When defined, byte 0x08 is a backspace:
  - count=2: dig0←dig1, dig1←0, count←1.
  - count=1: dig0←0, count←0, go to EMPTY.
  - EMPTY: ignored.
  - ISSUE/WAIT: overrun_tick, as for any other byte.
  - Never raises err_tick.
- When undefined, 0x08 is an "other" character and produces err_tick plus a buffer clear.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum (EMPTY, COLLECT, ISSUE, WAIT);
  - ASCII constants ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_CR=8'h0D, ASCII_BS=8'h08;
  - BCD digit width constant 4.
- One combinational sub-module, ascii_digit_decode: rx_data → is_digit, is_term, is_bs, value[3:0]. The FSM and digit registers stay in the top.

Test Plan:
- Bytes "4","2",CR with conv_ready=1 → start pulse 1 cycle after CR with dig1=4, dig0=2. busy=1 until conv_done, then dig1=dig0=0 and busy=0.
- Bytes "7",CR → start with dig1=0, dig0=7. CR alone in EMPTY → no start, no err_tick.
- Bytes "1","2","3" → err_tick on "3", count=0. Then "5",CR → start with dig1=0, dig0=5.
- Bytes "9","A" → err_tick on "A", buffer cleared. Separately, "3",CR with conv_ready held 0 for 5 cycles → start only in the cycle conv_ready rises, exactly one cycle wide.
- While in WAIT, send "8" in the same cycle as conv_done → overrun_tick=1, return to EMPTY with count=0, no stored digit.
- With ASCII_BCD_BACKSPACE_EN: "5","6",0x08,"1",CR → dig1=5, dig0=1. Without it, 0x08 → err_tick. Separately, assert rst_n low after "4" → all outputs 0 and no start follows a later CR.
